// File: rtl/instruction_fetch.sv
// instruction_fetch: one-word-at-a-time fetch from 1-cycle synchronous RAM with valid/ready to decode.
// Optional misaligned-fetch trap built when IFETCH_MISALIGN_TRAP_EN is defined.
module instruction_fetch #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_BITS = 16,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] pc_addr,
  output logic                 pc_en,
  output logic [ADDR_BITS-1:0] imem_addr,
  output logic                 imem_rden,
  input  logic [WORD_SIZE-1:0] imem_q,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic                 instr_fault
);
`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
  logic misalign;
  assign misalign = |pc_addr[1:0];
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  logic misalign;
  assign misalign = 1'b0;
`endif
  state_t               state_q;
  logic [WORD_SIZE-1:0] fetch_pc_q, instr_q, pc_q;
  logic                 valid_q, fault_q;
  assign imem_addr   = pc_addr[ADDR_BITS+1:2];
  assign imem_rden   = !rst && !flush && state_q == S_REQ && fetch_en && !misalign;
  // the counter advances only while the read data is actually being latched
  assign pc_en       = !rst && !flush && state_q == S_WAIT;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;
  assign instr_fault = fault_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= '0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else if (flush) begin
      state_q <= S_REQ;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: if (fetch_en) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (misalign) begin
            state_q <= S_FAULT;
            instr_q <= NOP_INSTR;
            pc_q    <= pc_addr;
            valid_q <= 1'b1;
            fault_q <= 1'b1;
          end else
`endif
          begin
            fetch_pc_q <= pc_addr;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          instr_q <= imem_q;
          pc_q    <= fetch_pc_q;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: if (instr_ready) begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
          state_q <= S_REQ;
        end
        default: state_q <= state_q;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven cycle vectors plus hand sequences for latency and misalignment.
module tb_instruction_fetch;
  localparam logic [31:0] N = 32'h00000013;
  localparam logic [31:0] A = 32'h00500093;
  localparam logic [31:0] B = 32'h00A00113;
  localparam logic [31:0] C = 32'h11111111;
  localparam logic [31:0] E = 32'h22222222;
  logic clk = 0, rst = 1, fetch_en = 0, flush = 0, instr_ready = 0;
  logic [31:0] pc_addr = 0, imem_q = 0, instr, instr_pc;
  logic pc_en, imem_rden, instr_valid, instr_fault;
  logic [15:0] imem_addr;
  logic [31:0] ram [0:255];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_rden) imem_q <= ram[imem_addr[7:0]];
  instruction_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .flush(flush), .pc_addr(pc_addr),
    .pc_en(pc_en), .imem_addr(imem_addr), .imem_rden(imem_rden), .imem_q(imem_q),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_fault(instr_fault)
  );
  typedef struct {
    logic rst, fe, fl, rdy;
    logic [31:0] pc;
    logic pcen, rden, valid;
    logic [31:0] ins, ipc;
  } vec_t;
  vec_t vt [30];
  function automatic vec_t mk(logic r, logic fe, logic fl, logic rdy, logic [31:0] pc,
                              logic pcen, logic rden, logic valid, logic [31:0] ins, logic [31:0] ipc);
    vec_t v;
    v.rst = r; v.fe = fe; v.fl = fl; v.rdy = rdy; v.pc = pc;
    v.pcen = pcen; v.rden = rden; v.valid = valid; v.ins = ins; v.ipc = ipc;
    return v;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic fe, input logic fl, input logic rdy, input logic [31:0] pc);
    @(negedge clk);
    rst = r; fetch_en = fe; flush = fl; instr_ready = rdy; pc_addr = pc;
    #2;
  endtask
  initial begin
    int n, pulses;
    for (int i = 0; i < 256; i++) ram[i] = 32'hDEAD0000 | i;
    ram[0] = A; ram[1] = C; ram[2] = E; ram[16] = B;
    vt[0]  = mk(1,1,0,1,32'h0,      0,0,0,N,32'h0);
    vt[1]  = mk(0,1,0,1,32'h0,      0,1,0,N,32'h0);
    vt[2]  = mk(0,1,0,1,32'h0,      1,0,0,N,32'h0);
    for (int i = 3; i < 8; i++) vt[i] = mk(0,1,0,0,32'h4, 0,0,1,A,32'h0);
    vt[8]  = mk(0,1,0,1,32'h4,      0,0,1,A,32'h0);
    vt[9]  = mk(0,1,0,1,32'h4,      0,1,0,N,32'h0);
    vt[10] = mk(0,1,0,1,32'h4,      1,0,0,N,32'h0);
    vt[11] = mk(0,1,0,1,32'h8,      0,0,1,C,32'h4);
    vt[12] = mk(0,1,0,1,32'h8,      0,1,0,N,32'h4);
    vt[13] = mk(0,1,1,1,32'h8,      0,0,0,N,32'h4);
    vt[14] = mk(0,1,0,1,32'h40,     0,1,0,N,32'h4);
    vt[15] = mk(0,1,0,0,32'h40,     1,0,0,N,32'h4);
    vt[16] = mk(0,1,0,0,32'h44,     0,0,1,B,32'h40);
    vt[17] = mk(0,1,1,1,32'h44,     0,0,1,B,32'h40);
    for (int i = 18; i < 22; i++) vt[i] = mk(0,0,0,1,32'h44, 0,0,0,N,32'h40);
    vt[22] = mk(0,1,0,0,32'h40004,  0,1,0,N,32'h40);
    vt[23] = mk(0,1,0,0,32'h40004,  1,0,0,N,32'h40);
    vt[24] = mk(1,1,0,0,32'h40004,  0,0,1,C,32'h40004);
    vt[25] = mk(0,0,0,0,32'h0,      0,0,0,N,32'h0);
    vt[26] = mk(0,1,0,0,32'h8,      0,1,0,N,32'h0);
    vt[27] = mk(1,1,0,0,32'h8,      0,0,0,N,32'h0);
    vt[28] = mk(0,0,0,0,32'h8,      0,0,0,N,32'h0);
    vt[29] = mk(0,1,1,0,32'h0,      0,0,0,N,32'h0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      drive(vt[i].rst, vt[i].fe, vt[i].fl, vt[i].rdy, vt[i].pc);
      check($sformatf("r%0d_pc_en", i), {31'b0, pc_en}, {31'b0, vt[i].pcen});
      check($sformatf("r%0d_rden", i), {31'b0, imem_rden}, {31'b0, vt[i].rden});
      check($sformatf("r%0d_iaddr", i), {16'b0, imem_addr}, {16'b0, vt[i].pc[17:2]});
      check($sformatf("r%0d_valid", i), {31'b0, instr_valid}, {31'b0, vt[i].valid});
      check($sformatf("r%0d_instr", i), instr, vt[i].ins);
      check($sformatf("r%0d_ipc", i), instr_pc, vt[i].ipc);
      check($sformatf("r%0d_fault", i), {31'b0, instr_fault}, 32'h0);
    end
    drive(0, 1, 0, 0, 32'h40);
    n = 0; pulses = 0;
    while (!instr_valid && n < 10) begin
      if (pc_en) pulses++;
      drive(0, 1, 0, 0, 32'h44);
      n++;
    end
    check("lat_cycles", n, 2);
    check("lat_pulses", pulses, 1);
    check("lat_instr", instr, B);
    check("lat_ipc", instr_pc, 32'h40);
    repeat (2) begin
      drive(0, 1, 0, 0, 32'h44);
      check("hold_pc_en", {31'b0, pc_en}, 32'h0);
      check("hold_instr", instr, B);
    end
    drive(0, 0, 0, 1, 32'h44);
    drive(0, 0, 0, 0, 32'h44);
    check("xfer_valid", {31'b0, instr_valid}, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    drive(0, 1, 0, 0, 32'h6);
    check("mis_rden", {31'b0, imem_rden}, 32'h0);
    drive(0, 1, 0, 1, 32'h6);
    check("mis_fault", {31'b0, instr_fault}, 32'h1);
    check("mis_valid", {31'b0, instr_valid}, 32'h1);
    check("mis_instr", instr, N);
    check("mis_ipc", instr_pc, 32'h6);
    check("mis_pc_en", {31'b0, pc_en}, 32'h0);
    drive(0, 1, 0, 1, 32'h6);
    check("mis_held", {31'b0, instr_fault}, 32'h1);
    check("mis_held_rden", {31'b0, imem_rden}, 32'h0);
    drive(0, 1, 1, 1, 32'h6);
    check("mis_flushcyc", {31'b0, instr_fault}, 32'h1);
    drive(0, 0, 0, 0, 32'h8);
    check("mis_cleared", {31'b0, instr_fault}, 32'h0);
    check("mis_cleared_valid", {31'b0, instr_valid}, 32'h0);
`else
    drive(0, 1, 0, 0, 32'h6);
    check("mis_rden", {31'b0, imem_rden}, 32'h1);
    check("mis_iaddr", {16'b0, imem_addr}, 32'h1);
    drive(0, 1, 0, 0, 32'h6);
    check("mis_pc_en", {31'b0, pc_en}, 32'h1);
    drive(0, 0, 0, 1, 32'hA);
    check("mis_instr", instr, C);
    check("mis_ipc", instr_pc, 32'h6);
    check("mis_fault", {31'b0, instr_fault}, 32'h0);
    drive(0, 0, 0, 0, 32'hA);
    check("mis_done", {31'b0, instr_valid}, 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
